// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int          CLK_HZ       = 200_000_000,
    parameter int          BAUD         = 9600,
    parameter logic [15:0] BAUD_DIVISOR = 16'(CLK_HZ / BAUD),
    parameter int          STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    // state  | meaning
    // IDLE   | line high, waiting for tx_start
    // START  | start bit (txd = 0)
    // DATA   | 8 data bits, LSB first
    // PARITY | parity bit (only with UART_TX_PARITY_EN)
    // STOP   | STOP_BITS stop periods (txd = 1)
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] CNT_RELOAD = BAUD_DIVISOR - 16'd1;
    localparam logic        LAST_STOP  = (STOP_BITS == 2);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        stop_idx;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`else
    logic        unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shreg   <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^tx_data) ^ PARITY_ODD;
`endif
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                        cnt     <= CNT_RELOAD;
                        state   <= START;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                default: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        cnt <= CNT_RELOAD;
                        case (state)
                            START: begin
                                txd     <= shreg[0];
                                bit_idx <= 3'd0;
                                state   <= DATA;
                            end
                            DATA: begin
                                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                    txd   <= par_bit;
                                    state <= PARITY;
`else
                                    txd      <= 1'b1;
                                    stop_idx <= 1'b0;
                                    state    <= STOP;
`endif
                                end else begin
                                    shreg   <= shreg >> 1;
                                    txd     <= shreg[1];
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
`ifdef UART_TX_PARITY_EN
                            PARITY: begin
                                txd      <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
`endif
                            STOP: begin
                                if (stop_idx == LAST_STOP) begin
                                    tx_done <= 1'b1;
                                    // A held request chains the next frame with no idle cycle.
                                    if (tx_start) begin
                                        shreg   <= tx_data;
`ifdef UART_TX_PARITY_EN
                                        par_bit <= (^tx_data) ^ PARITY_ODD;
`endif
                                        txd     <= 1'b0;
                                        tx_busy <= 1'b1;
                                        state   <= START;
                                    end else begin
                                        txd     <= 1'b1;
                                        tx_busy <= 1'b0;
                                        state   <= IDLE;
                                    end
                                end else begin
                                    stop_idx <= 1'b1;
                                end
                            end
                            default: begin
                                txd     <= 1'b1;
                                tx_busy <= 1'b0;
                                state   <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames compared cycle by cycle against a bit-level frame model.
module tb_uart_tx;

    localparam int D = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P       = 1;
    localparam int STOP_TB = 2;
`else
    localparam int P       = 0;
    localparam int STOP_TB = 1;
`endif
    localparam int N = 9 + P + STOP_TB;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, txd;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(STOP_TB), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .nrst(nrst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd)
    );

`ifdef UART_TX_PARITY_EN
    logic busy_odd, done_odd, txd_odd;
    uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(STOP_TB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .nrst(nrst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(busy_odd), .tx_done(done_odd), .txd(txd_odd)
    );
`endif

    // Bit k of a frame: 0 = start, 1..8 = data LSB first, then parity (if present), then stop bits.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (P == 1 && k == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // Called at the negedge right after the accepting edge; ends at the negedge of cycle N*D.
    task automatic check_frame(input logic [7:0] d, input logic done_first, input logic hold,
                               input logic disturb, input logic [7:0] next_d);
        logic exp_bit;
        tx_start = hold;
        for (int c = 0; c < N * D; c++) begin
            exp_bit = frame_bit(d, c / D, 1'b0);
            checks++;
            if (txd !== exp_bit) begin
                errors++;
                $display("FAIL frame_txd data=%02h cycle=%0d got=%b exp=%b", d, c, txd, exp_bit);
            end
            checks++;
            if (tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL frame_busy data=%02h cycle=%0d got=%b exp=1", d, c, tx_busy);
            end
            checks++;
            if (tx_done !== ((c == 0) ? done_first : 1'b0)) begin
                errors++;
                $display("FAIL frame_done data=%02h cycle=%0d got=%b", d, c, tx_done);
            end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (txd_odd !== frame_bit(d, c / D, 1'b1)) begin
                errors++;
                $display("FAIL frame_txd_odd data=%02h cycle=%0d got=%b", d, c, txd_odd);
            end
`endif
            if (disturb && c < N * D - 1) begin
                tx_data  = (c == 0) ? ~d : 8'($urandom);
                tx_start = 1'($urandom_range(0, 1));
            end
            if (c == N * D - 1) begin
                tx_data  = next_d;
                tx_start = hold;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_end_idle(input string name);
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL %s_end got done=%b busy=%b txd=%b exp 1/0/1", name, tx_done, tx_busy, txd);
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got done=%b busy=%b txd=%b exp 0/0/1", name, tx_done, tx_busy, txd);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        nrst     = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d got txd=%b busy=%b done=%b exp 1/0/0", i, txd, tx_busy, tx_done);
            end
        end
        d = 8'($urandom);
        tx_data = d;
        nrst = 1'b1;
        @(negedge clk);
        check_frame(d, 1'b0, 1'b0, 1'b0, 8'h00);
        check_end_idle("reset_first");
    endtask

    task automatic test_single();
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        check_end_idle("single");
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00);
        check_frame(8'h00, 1'b0, 1'b1, 1'b0, 8'hFF);
        check_frame(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
        check_end_idle("b2b");
    endtask

    task automatic test_parity();
        start_frame(8'h07);
        check_frame(8'h07, 1'b0, 1'b0, 1'b0, 8'h00);
        check_end_idle("parity");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        start_frame(8'h55);
        tx_start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            checks++;
            if (txd !== frame_bit(8'h55, c / D, 1'b0)) begin
                errors++;
                $display("FAIL midrst_pre cycle=%0d got=%b", c, txd);
            end
            if (c == 44) nrst = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort got txd=%b busy=%b done=%b exp 1/0/0", txd, tx_busy, tx_done);
        end
        nrst = 1'b1;
        for (int i = 0; i < 3 * N * D; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after cycle=%0d got txd=%b busy=%b done=%b exp 1/0/0", i, txd, tx_busy, tx_done);
            end
        end
        d = 8'($urandom);
        start_frame(d);
        check_frame(d, 1'b0, 1'b0, 1'b0, 8'h00);
        check_end_idle("midrst_clean");
    endtask

    task automatic test_data_stability();
        start_frame(8'h3C);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8'h00);
        check_end_idle("stability");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int gap;
        for (int f = 0; f < 8; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (txd !== 1'b1 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL random_gap frame=%0d got txd=%b busy=%b", f, txd, tx_busy);
                end
            end
            d = 8'($urandom);
            start_frame(d);
            check_frame(d, 1'b0, 1'b0, 1'b1, 8'($urandom));
            tx_start = 1'b0;
            check_end_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_data_stability();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
